sqrt_req_master: RTL and testbench
==================================

// Module: sqrt_req_master
// PURPOSE
//  Initiator side of the valid/wdata/ready/rdata four-phase coprocessor handshake.
//  Takes operands from an upstream stream port and issues one request at a time
//  to a coprocessor responder such as fpsqrt.
//  Returns each result downstream, with an optional timeout error flag.
//  Sits between a CPU-side job queue and the coprocessor.
// PARAMETERS
//  DATA_W          32    operand/result width (co_wdata, co_rdata, in_data, out_data)
//  CNT_W           16    width of done_count
//  TIMEOUT_CYCLES  1024  max cycles co_valid waits for co_ready (REQ_TIMEOUT_EN only)
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-high reset
//  in_valid    in   1        upstream operand valid
//  in_data     in   DATA_W   upstream operand
//  in_ready    out  1        block can accept an operand this cycle
//  out_valid   out  1        result valid, held until out_ready
//  out_data    out  DATA_W   result (co_rdata captured)
//  out_err     out  1        result aborted by timeout (0 if REQ_TIMEOUT_EN undefined)
//  out_ready   in   1        downstream accepts result
//  co_valid    out  1        request to responder
//  co_wdata    out  DATA_W   operand to responder, stable while co_valid=1
//  co_ready    in   1        responder result valid
//  co_rdata    in   DATA_W   responder result
//  busy        out  1        state != IDLE
//  done_count  out  CNT_W    results delivered downstream, including error results
// BEHAVIOUR
//  Reset: state=IDLE; all outputs are 0.
//   - Covers co_valid, co_wdata, out_valid, out_data, out_err, done_count and busy.
//   - Reset mid-transaction aborts the job silently; no result is emitted.
//  FSM states: IDLE, REQ, RELEASE, OUT.
//  IDLE
//   - in_ready = !co_ready. A stale responder ready must drain before a new job.
//   - Accept on in_valid & in_ready at edge N: co_wdata<=in_data, co_valid<=1 from N+1, go REQ.
//  REQ
//   - co_valid=1 and co_wdata held.
//   - On the first edge with co_ready=1: out_data<=co_rdata, out_err<=0, co_valid<=0, go RELEASE.
//  RELEASE
//   - co_valid=0. Wait for co_ready=0, then out_valid<=1 and go OUT.
//   - co_valid is never reasserted while co_ready=1. The responder clears ready only after it
//     samples valid low.
//  OUT
//   - out_valid=1; out_data and out_err are stable.
//   - On out_ready: out_valid<=0, done_count<=done_count+1 (wraps modulo 2^CNT_W), go IDLE.
//  Throughput: one job in flight; in_ready=0 in every state except IDLE.
//  out_ready asserted while out_valid=0 has no effect.
//  in_valid is ignored outside IDLE.
//  co_ready may already be high in the first REQ cycle (zero-latency responder). It is captured
//  on that edge.
//  Minimum cycles per job = 4 + responder latency + responder ready-drop latency.
// CONFIGURATION
//  REQ_TIMEOUT_EN defined
//   - A wait counter clears on entry to REQ and increments each cycle in REQ.
//   - When it reaches TIMEOUT_CYCLES with co_ready still 0: co_valid<=0, out_data<=0,
//     out_err<=1, go RELEASE.
//   - A co_ready arriving on the same edge as the timeout wins: normal result, out_err=0.
//  REQ_TIMEOUT_EN undefined
//   - No counter; REQ waits indefinitely; out_err is constant 0.
// TESTING
//  The bench pairs the block with the fpsqrt responder, unless a line names a model.
//  1 in_data=0x00000090 -> out_data=0x0000000C, out_err=0, done_count=1,
//    co_valid low before out_valid.
//  2 Back-to-back jobs 0xFFFFFFFF then 0x00000000 -> 0x0000FFFF then 0x00000000.
//    Second co_valid rises only after co_ready=0; done_count=2.
//  3 out_ready held 0 for 20 cycles after out_valid -> out_data stable, in_ready=0,
//    no new co_valid.
//  4 reset=1 for 1 cycle during REQ -> next cycle co_valid=0, out_valid=0, done_count=0.
//    in_ready=0 while responder co_ready=1.
//  5 REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, model with co_ready stuck 0 -> after 8 REQ cycles
//    co_valid=0, out_valid=1, out_err=1, out_data=0.
//  6 Model responder with 0-cycle latency (co_ready=1 in first REQ cycle) -> result captured,
//    single request pulse, no duplicate job.

Source files
------------

// File: rtl/sqrt_req_master.sv
// Initiator side of the four-phase valid/wdata/ready/rdata coprocessor handshake.
// Define REQ_TIMEOUT_EN to abort requests the responder leaves unanswered for TIMEOUT_CYCLES.
module sqrt_req_master #(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              out_ready,
  output logic              co_valid,
  output logic [DATA_W-1:0] co_wdata,
  input  logic              co_ready,
  input  logic [DATA_W-1:0] co_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  done_count,
  output logic [1:0]        o_dbg_state
);

  // Stream ports transfer on a rising edge with valid && ready; the coprocessor side is
  // four-phase: co_valid holds until co_ready, then ready must fall before a new request.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic              r_co_valid, w_co_valid_nx;
  logic [DATA_W-1:0] r_co_wdata, w_co_wdata_nx;
  logic              r_out_valid, w_out_valid_nx;
  logic [DATA_W-1:0] r_out_data, w_out_data_nx;
  logic              r_out_err, w_out_err_nx;
  logic [CNT_W-1:0]  r_done_count, w_done_count_nx;
  logic              w_timeout;

`ifdef REQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_wait_cnt;

  // Counts REQ cycles; zero in the first REQ cycle, so TO_LAST marks the last allowed one.
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_REQ)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state == S_REQ) && (r_wait_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign in_ready    = (r_state == S_IDLE) && !co_ready;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
  assign co_valid    = r_co_valid;
  assign co_wdata    = r_co_wdata;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_err     = r_out_err;
  assign done_count  = r_done_count;

  always_comb begin
    w_state_nx      = r_state;
    w_co_valid_nx   = r_co_valid;
    w_co_wdata_nx   = r_co_wdata;
    w_out_valid_nx  = r_out_valid;
    w_out_data_nx   = r_out_data;
    w_out_err_nx    = r_out_err;
    w_done_count_nx = r_done_count;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_co_wdata_nx = in_data;
          w_co_valid_nx = 1'b1;
          w_state_nx    = S_REQ;
        end
      end
      S_REQ: begin
        // A result on the timeout edge still counts as a normal result.
        if (co_ready) begin
          w_out_data_nx = co_rdata;
          w_out_err_nx  = 1'b0;
          w_co_valid_nx = 1'b0;
          w_state_nx    = S_RELEASE;
        end else if (w_timeout) begin
          w_out_data_nx = '0;
          w_out_err_nx  = 1'b1;
          w_co_valid_nx = 1'b0;
          w_state_nx    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!co_ready) begin
          w_out_valid_nx = 1'b1;
          w_state_nx     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_out_valid_nx  = 1'b0;
          w_done_count_nx = r_done_count + CNT_W'(1);
          w_state_nx      = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_co_valid   <= 1'b0;
      r_co_wdata   <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_co_valid   <= w_co_valid_nx;
      r_co_wdata   <= w_co_wdata_nx;
      r_out_valid  <= w_out_valid_nx;
      r_out_data   <= w_out_data_nx;
      r_out_err    <= w_out_err_nx;
      r_done_count <= w_done_count_nx;
    end
  end

endmodule

// File: tb/tb_sqrt_req_master.sv
// Bench for sqrt_req_master: behavioural integer-sqrt responder, random sink, result scoreboard.
// Define REQ_TIMEOUT_EN to also exercise the request timeout (TIMEOUT_CYCLES=8).
module tb_sqrt_req_master;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int TMO    = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic              out_ready;
  logic              co_valid;
  logic [DATA_W-1:0] co_wdata;
  logic              co_ready;
  logic [DATA_W-1:0] co_rdata;
  logic              busy;
  logic [CNT_W-1:0]  done_count;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad = 0;
  logic [DATA_W:0]  exp_q[$];
  logic [DATA_W:0]  got_q[$];
  logic [CNT_W-1:0] exp_done = '0;
  int resp_lat = 2;
  int resp_drop = 1;
  bit resp_stuck = 1'b0;
  int req_cnt = 0;
  int sink_mode = 0;

  sqrt_req_master #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready),
    .co_valid(co_valid), .co_wdata(co_wdata), .co_ready(co_ready), .co_rdata(co_rdata),
    .busy(busy), .done_count(done_count), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] isqrt(input logic [DATA_W-1:0] x);
    longint xv, r;
    xv = longint'(x);
    r = longint'($sqrt(real'(xv)));
    while (r * r > xv) r--;
    while ((r + 1) * (r + 1) <= xv) r++;
    return r[DATA_W-1:0];
  endfunction

  // ---------------- responder model ----------------
  initial begin : responder
    int rs;
    int cnt;
    logic [DATA_W-1:0] pend;
    rs = 0; cnt = 0; pend = '0;
    co_ready = 1'b0; co_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rs == 0 && co_valid) begin
        req_cnt++;
        pend = isqrt(co_wdata);
        cnt = resp_lat;
        rs = 1;
      end
      if (rs == 1) begin
        if (resp_stuck) begin
          if (!co_valid) rs = 0;
        end else if (cnt == 0) begin
          co_ready = 1'b1; co_rdata = pend; rs = 2;
        end else begin
          cnt--;
        end
      end else if (rs == 2) begin
        if (!co_valid) begin cnt = resp_drop; rs = 3; end
      end
      if (rs == 3) begin
        if (cnt == 0) begin co_ready = 1'b0; co_rdata = $urandom; rs = 0; end
        else cnt--;
      end
    end
  end

  // ---------------- downstream sink ----------------
  initial begin : sink
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic p_cov, p_crdy, p_ov, p_ordy;
    logic [DATA_W-1:0] p_wd, p_od;
    logic [DATA_W:0] e;
    p_cov = 0; p_crdy = 0; p_ov = 0; p_ordy = 0; p_wd = '0; p_od = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (co_valid && !p_cov) check_eq("req_rise_ready_low", p_crdy, 0);
        if (co_valid && p_cov) check_eq("co_wdata_hold", co_wdata, p_wd);
        if (out_valid && !p_ov) begin
          check_eq("out_rise_co_valid_low", co_valid, 0);
          check_eq("out_rise_co_ready_low", p_crdy, 0);
        end
        if (p_ov && !p_ordy) begin
          check_eq("out_valid_held", out_valid, 1);
          check_eq("out_data_hold", out_data, p_od);
        end
        if (out_valid && out_ready) begin
          check_eq("result_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("out_data", out_data, e[DATA_W-1:0]);
            check_eq("out_err", out_err, e[DATA_W]);
          end
          check_eq("done_count", done_count, exp_done);
          exp_done = exp_done + 1'b1;
          got_q.push_back({out_err, out_data});
        end
      end
      p_cov = co_valid; p_crdy = co_ready; p_ov = out_valid; p_ordy = out_ready;
      p_wd = co_wdata; p_od = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_job(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 500) begin @(posedge clk); #2; n++; end
    check_eq("accept", in_ready, 1);
    if (in_ready) begin
      if (resp_stuck) exp_q.push_back({1'b1, {DATA_W{1'b0}}});
      else exp_q.push_back({1'b0, isqrt(d)});
      @(posedge clk); #2;
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || co_ready || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk); #2; n++;
    end
    check_eq("idle_reached", n < 2000, 1);
  endtask

  task automatic count_req_cycles(output int n);
    n = 0;
    while (co_valid && n < 100) begin n++; @(posedge clk); #2; end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n, rc0;
    logic [15:0] k;
    logic [DATA_W-1:0] d;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_co_valid", co_valid, 0);
    check_eq("rst_co_wdata", co_wdata, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_done_count", done_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, 0);
    reset = 1'b0;

    // 1: single job
    resp_lat = 3; resp_drop = 1; got_q.delete();
    send_job(32'h0000_0090);
    wait_idle();
    check_eq("t1_count", got_q.size(), 1);
    check_eq("t1_result", got_q[0], {1'b0, 32'h0000_000C});
    check_eq("t1_done", done_count, 1);

    // 2: back-to-back extremes
    resp_lat = 1; resp_drop = 3; got_q.delete();
    send_job(32'hFFFF_FFFF);
    send_job(32'h0000_0000);
    wait_idle();
    check_eq("t2_count", got_q.size(), 2);
    check_eq("t2_result0", got_q[0], {1'b0, 32'h0000_FFFF});
    check_eq("t2_result1", got_q[1], {1'b0, 32'h0000_0000});
    check_eq("t2_done", done_count, 3);

    // 6: zero-latency responder
    resp_lat = 0; resp_drop = 0; got_q.delete(); rc0 = req_cnt;
    send_job(32'd81);
    count_req_cycles(n);
    check_eq("t6_req_cycles", n, 1);
    wait_idle();
    repeat (5) @(posedge clk);
    #2;
    check_eq("t6_requests", req_cnt - rc0, 1);
    check_eq("t6_result", got_q[0], {1'b0, 32'd9});
    check_eq("t6_done", done_count, 4);

    // 3: downstream stall with upstream pressure
    resp_lat = 1; resp_drop = 1; sink_mode = 2; got_q.delete();
    send_job(32'd400);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #2; n++; end
    check_eq("t3_out_valid", out_valid, 1);
    in_valid = 1'b1; in_data = 32'h1234; rc0 = req_cnt;
    repeat (20) begin
      @(posedge clk); #2;
      check_eq("t3_data", out_data, 32'h14);
      check_eq("t3_in_ready", in_ready, 0);
      check_eq("t3_co_valid", co_valid, 0);
    end
    in_valid = 1'b0; in_data = '0; sink_mode = 0;
    check_eq("t3_no_request", req_cnt - rc0, 0);
    wait_idle();
    check_eq("t3_count", got_q.size(), 1);
    check_eq("t3_done", done_count, 5);

    // 4: reset during REQ
    resp_lat = 6; resp_drop = 1; got_q.delete(); rc0 = req_cnt;
    send_job(32'd1000);
    repeat (2) begin @(posedge clk); #2; end
    check_eq("t4_busy_pre", busy, 1);
    check_eq("t4_co_valid_pre", co_valid, 1);
    reset = 1'b1;
    @(posedge clk); #2;
    check_eq("t4_co_valid", co_valid, 0);
    check_eq("t4_out_valid", out_valid, 0);
    check_eq("t4_done", done_count, 0);
    check_eq("t4_busy", busy, 0);
    reset = 1'b0; exp_q.delete(); exp_done = '0;
    n = 0;
    while (!co_ready && n < 50) begin @(posedge clk); #2; n++; end
    check_eq("t4_resp_ready", co_ready, 1);
    check_eq("t4_in_ready_blocked", in_ready, 0);
    n = 0;
    while (co_ready && n < 50) begin @(posedge clk); #2; n++; end
    repeat (5) @(posedge clk);
    #2;
    check_eq("t4_no_result", got_q.size(), 0);
    check_eq("t4_out_valid_after", out_valid, 0);
    check_eq("t4_single_request", req_cnt - rc0, 1);

`ifdef REQ_TIMEOUT_EN
    // 5: responder never answers
    resp_stuck = 1'b1; got_q.delete();
    send_job(32'd49);
    count_req_cycles(n);
    check_eq("t5_req_cycles", n, TMO);
    wait_idle();
    check_eq("t5_result", got_q[0], {1'b1, 32'h0});
    check_eq("t5_done", done_count, exp_done);
    resp_stuck = 1'b0;
`endif

    // random jobs, random latencies and downstream backpressure
    sink_mode = 1;
    for (int i = 0; i < 40; i++) begin
      resp_lat = $urandom_range(0, 4);
      resp_drop = $urandom_range(0, 3);
      k = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = $urandom_range(0, 300);
        2:       d = {16'b0, k} * {16'b0, k};
        default: d = ({16'b0, k} * {16'b0, k}) - 32'd1;
      endcase
      send_job(d);
    end
    wait_idle();
    check_eq("rand_done", done_count, exp_done);
    sink_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
